bp_be_fcsr_unit: RTL

Floating-point control/status unit for the BlackParrot backend: holds the sticky `fflags` and the `frm` rounding mode and merges exception flags from up to `num_ports_p` retiring FP pipes each cycle. It also services CSR reads and writes to `fflags`, `frm` and `fcsr` through a single-entry buffered response channel. It resolves dynamic rounding modes for instructions entering FP pipes. It sits beside the CSR file in the backend, between the commit stage and the FP execution pipes.

---
 rtl/bp_common_rv64_pkg.sv | 51 +++++
 rtl/bp_be_fflags_reduce.sv | 31 +++
 rtl/bp_be_fcsr_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/bp_common_rv64_pkg.sv
// Shared RV64 types for the FP control/status path: fflags/frm encodings,
// the fcsr layout, CSR operation codes and the fcsr read-modify-write helper.
package bp_common_rv64_pkg;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } rv64_fflags_s;

  typedef enum logic [2:0] {
    e_rne = 3'b000,
    e_rtz = 3'b001,
    e_rdn = 3'b010,
    e_rup = 3'b011,
    e_rmm = 3'b100,
    e_dyn = 3'b111
  } rv64_frm_e;

  typedef enum logic [1:0] {
    e_fcsr_read  = 2'b00,
    e_fcsr_write = 2'b01,
    e_fcsr_set   = 2'b10,
    e_fcsr_clear = 2'b11
  } bp_fcsr_op_e;

  localparam logic [11:0] rv64_csr_fflags_gp = 12'h001;
  localparam logic [11:0] rv64_csr_frm_gp    = 12'h002;
  localparam logic [11:0] rv64_csr_fcsr_gp   = 12'h003;

  // frm is kept as raw bits because reserved encodings are storable
  typedef struct packed {
    logic [2:0]   frm;
    rv64_fflags_s fflags;
  } rv64_fcsr_s;

  // Read-modify-write on the 8-bit fcsr image; callers pick which fields to keep
  function automatic logic [7:0] fcsr_alu(input bp_fcsr_op_e op,
                                          input logic [7:0] old_val,
                                          input logic [7:0] opnd);
    case (op)
      e_fcsr_write: fcsr_alu = opnd;
      e_fcsr_set:   fcsr_alu = old_val | opnd;
      e_fcsr_clear: fcsr_alu = old_val & ~opnd;
      default:      fcsr_alu = old_val;
    endcase
  endfunction

endpackage

// File: rtl/bp_be_fflags_reduce.sv
// OR-reduction of the valid-masked exception flags from all retiring FP ports.
module bp_be_fflags_reduce
  import bp_common_rv64_pkg::*;
#(
  parameter int num_ports_p = 2
) (
  input  logic [num_ports_p-1:0]   v_i,
  input  logic [num_ports_p*5-1:0] flags_i,
  output rv64_fflags_s             flags_o
);

  logic [num_ports_p-1:0][4:0] masked;

  genvar gi;
  generate
    for (gi = 0; gi < num_ports_p; gi++) begin : g_mask
      assign masked[gi] = v_i[gi] ? flags_i[gi*5 +: 5] : 5'b0;
    end
  endgenerate

  // Fold every port's masked flags together
  always_comb begin
    logic [4:0] acc;
    acc = 5'b0;
    for (int k = 0; k < num_ports_p; k++) begin
      acc = acc | masked[k];
    end
    flags_o = rv64_fflags_s'(acc);
  end

endmodule

// File: rtl/bp_be_fcsr_unit.sv
// Floating-point control/status unit: sticky fflags, frm, CSR access through a
// one-entry response buffer, and dynamic rounding-mode resolution.
// Optional macro BP_FCSR_DIRTY_TRACK_EN builds a real FS dirty bit; without it
// the FP state is reported permanently dirty.
module bp_be_fcsr_unit
  import bp_common_rv64_pkg::*;
#(
  parameter int num_ports_p = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [num_ports_p-1:0]   flags_v_i,
  input  logic [num_ports_p*5-1:0] flags_i,
  input  logic                     csr_v_i,
  output logic                     csr_ready_o,
  input  logic [1:0]               csr_op_i,
  input  logic [11:0]              csr_addr_i,
  input  logic [63:0]              csr_data_i,
  output logic                     csr_v_o,
  output logic [63:0]              csr_data_o,
  output logic                     csr_illegal_o,
  input  logic                     csr_yumi_i,
  input  logic [2:0]               instr_frm_i,
  output logic [2:0]               frm_o,
  output logic                     frm_illegal_o,
  output logic [4:0]               fflags_o,
  output logic [2:0]               frm_r_o,
  output logic                     fs_dirty_o,
  input  logic                     fs_clean_i
);

  logic [4:0]   fflags_r, fflags_n;
  logic [2:0]   frm_r, frm_n;
  rv64_fflags_s retire_flags;
  logic         accept, legal, state_write;
  logic [7:0]   old_byte, opnd_byte, alu_byte;
  logic [63:0]  old_data;
  bp_fcsr_op_e  op;

  bp_be_fflags_reduce #(.num_ports_p(num_ports_p)) u_reduce (
    .v_i     (flags_v_i),
    .flags_i (flags_i),
    .flags_o (retire_flags)
  );

  assign op          = bp_fcsr_op_e'(csr_op_i);
  assign csr_ready_o = ~csr_v_o | csr_yumi_i;
  assign accept      = csr_v_i & csr_ready_o;
  assign legal       = (csr_addr_i == rv64_csr_fflags_gp)
                     | (csr_addr_i == rv64_csr_frm_gp)
                     | (csr_addr_i == rv64_csr_fcsr_gp);
  assign state_write = accept & legal & (op != e_fcsr_read);
  assign old_byte    = {frm_r, fflags_r};
  assign alu_byte    = fcsr_alu(op, old_byte, opnd_byte);

  // Place the operand in the fcsr image and capture the pre-cycle value for reads
  always_comb begin
    opnd_byte = 8'b0;
    old_data  = 64'b0;
    case (csr_addr_i)
      rv64_csr_fflags_gp: begin
        opnd_byte = {3'b0, csr_data_i[4:0]};
        old_data  = {59'b0, fflags_r};
      end
      rv64_csr_frm_gp: begin
        opnd_byte = {csr_data_i[2:0], 5'b0};
        old_data  = {61'b0, frm_r};
      end
      rv64_csr_fcsr_gp: begin
        opnd_byte = csr_data_i[7:0];
        old_data  = {56'b0, old_byte};
      end
      default: ;
    endcase
  end

  // CSR result first, then same-cycle retired flags ORed on top
  always_comb begin
    fflags_n = fflags_r;
    frm_n    = frm_r;
    if (state_write) begin
      if (csr_addr_i != rv64_csr_frm_gp)    fflags_n = alu_byte[4:0];
      if (csr_addr_i != rv64_csr_fflags_gp) frm_n    = alu_byte[7:5];
    end
    fflags_n = fflags_n | retire_flags;
  end

  // Architectural state registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fflags_r <= 5'b0;
      frm_r    <= 3'b0;
    end else begin
      fflags_r <= fflags_n;
      frm_r    <= frm_n;
    end
  end

  // Single-entry response buffer: load on accept, drop on yumi, else hold
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      csr_v_o       <= 1'b0;
      csr_data_o    <= 64'b0;
      csr_illegal_o <= 1'b0;
    end else if (accept) begin
      csr_v_o       <= 1'b1;
      csr_data_o    <= legal ? old_data : 64'b0;
      csr_illegal_o <= ~legal;
    end else if (csr_yumi_i) begin
      csr_v_o       <= 1'b0;
    end
  end

  assign fflags_o      = fflags_r;
  assign frm_r_o       = frm_r;
  assign frm_o         = (instr_frm_i == e_dyn) ? frm_r : instr_frm_i;
  assign frm_illegal_o = (frm_o >= 3'b101);

`ifdef BP_FCSR_DIRTY_TRACK_EN
  logic fs_dirty_r;
  logic dirty_set;
  assign dirty_set = (|retire_flags) | state_write;

  // Dirty bit: any set condition overrides a same-cycle clean request
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)     fs_dirty_r <= 1'b0;
    else if (dirty_set) fs_dirty_r <= 1'b1;
    else if (fs_clean_i) fs_dirty_r <= 1'b0;
  end
  assign fs_dirty_o = fs_dirty_r;

  logic [55:0] unused_data;
  assign unused_data = csr_data_i[63:8];
`else
  assign fs_dirty_o = 1'b1;

  logic [56:0] unused_data;
  assign unused_data = {fs_clean_i, csr_data_i[63:8]};
`endif

endmodule
